sym_word_deserializer: RTL and testbench

//  Upstream feeder for the symmetry detector stage. Assembles framed serial bits into

---
 rtl/sym_word_deserializer.sv | 133 +++++++++++++
 tb/tb_sym_word_deserializer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_word_deserializer.sv
// Serial-to-parallel front end for the symmetry detector. It collects framed bits into
// WIDTH-bit words, holds each word on a valid/ready port, and flags overruns and broken frames.
module sym_word_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             ser_bit,
  input  logic             bit_sof,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CW-1:0]      bit_count_q, bit_count_d;
  logic [WIDTH-1:0]   word_data_q, word_data_d;
  logic               word_valid_q, word_valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;

  logic               word_complete;
  logic               transfer;
  logic [WIDTH-1:0]   shifted;

  // The first serial bit of a frame ends up at bit WIDTH-1 when MSB_FIRST, else at bit 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
    if (MSB_FIRST) return {sr[WIDTH-2:0], b};
    else           return {b, sr[WIDTH-1:1]};
  endfunction

  assign shifted  = shift_in(shift_q, ser_bit);
  assign transfer = word_valid_q && word_ready;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_count_d   = bit_count_q;
    frame_err_d   = 1'b0;
    word_complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (bit_valid && bit_sof) begin
          shift_d     = shift_in('0, ser_bit);
          bit_count_d = CW'(1);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          if (bit_sof) begin
            // A new frame started before the old one finished: drop the partial word.
            shift_d     = shift_in('0, ser_bit);
            bit_count_d = CW'(1);
            frame_err_d = 1'b1;
          end else if (bit_count_q == CW'(WIDTH - 1)) begin
            shift_d       = shifted;
            bit_count_d   = '0;
            word_complete = 1'b1;
            state_d       = IDLE;
          end else begin
            shift_d     = shifted;
            bit_count_d = bit_count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (clr_flags) overrun_d = 1'b0;

    if (word_complete) begin
      if (!word_valid_q || transfer) begin
        word_data_d  = shifted;
        word_valid_d = 1'b1;
      end else begin
        // Consumer still holds the previous word: the new one is lost.
        overrun_d = 1'b1;
      end
    end else if (transfer) begin
      word_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_count_q  <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_count_q  <= bit_count_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign bit_count  = bit_count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sym_word_deserializer.sv
// Directed bench for sym_word_deserializer: one MSB-first and one LSB-first instance
// share the same serial stimulus; each scenario task checks its own expected values.
module tb_sym_word_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       ser_bit = 1'b0;
  logic       bit_sof = 1'b0;
  logic       word_ready = 1'b0;
  logic       clr_flags = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [3:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr;
  logic       m_ferr, l_ferr;

  int checks = 0;
  int errors = 0;
  int m_xfers = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (m_valid && word_ready) m_xfers <= m_xfers + 1;

  sym_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .ser_bit(ser_bit), .bit_sof(bit_sof),
    .word_data(m_data), .word_valid(m_valid), .word_ready(word_ready),
    .bit_count(m_cnt), .overrun(m_ovr), .frame_err(m_ferr), .clr_flags(clr_flags)
  );

  sym_word_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .ser_bit(ser_bit), .bit_sof(bit_sof),
    .word_data(l_data), .word_valid(l_valid), .word_ready(word_ready),
    .bit_count(l_cnt), .overrun(l_ovr), .frame_err(l_ferr), .clr_flags(clr_flags)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit for exactly one edge; returns 1 time unit after that edge.
  task automatic send_bit(input logic b, input logic sof);
    bit_valid = 1'b1;
    ser_bit   = b;
    bit_sof   = sof;
    tick();
    bit_valid = 1'b0;
    bit_sof   = 1'b0;
  endtask

  // Serial order b0..b7 = w[7]..w[0]; sof on b0.
  task automatic send_frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_data, m_valid, m_cnt, m_ovr, m_ferr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_msb got data=%h v=%b cnt=%0d ovr=%b ferr=%b exp all 0", m_data, m_valid, m_cnt, m_ovr, m_ferr);
    end
    checks++;
    if ({l_data, l_valid, l_cnt, l_ovr, l_ferr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_lsb got data=%h v=%b cnt=%0d ovr=%b ferr=%b exp all 0", l_data, l_valid, l_cnt, l_ovr, l_ferr);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] w;
    w = 8'hBD;
    word_ready = 1'b1;
    for (int i = 7; i >= 5; i--) send_bit(w[i], i == 7);
    checks++;
    if (m_cnt !== 4'd3) begin
      errors++; $display("FAIL midframe_count got %0d exp 3", m_cnt);
    end
    for (int i = 4; i >= 0; i--) send_bit(w[i], 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hBD || m_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_word got v=%b data=%h cnt=%0d exp v=1 data=bd cnt=0", m_valid, m_data, m_cnt);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle got v=%b exp 0", m_valid);
    end
  endtask

  task automatic test_bit_order();
    word_ready = 1'b1;
    send_frame(8'hBD);
    checks++;
    if (l_valid !== 1'b1 || l_data !== 8'hBD) begin
      errors++; $display("FAIL lsb_palindrome got v=%b data=%h exp v=1 data=bd", l_valid, l_data);
    end
    send_frame(8'h80);
    checks++;
    if (l_data !== 8'h01) begin
      errors++; $display("FAIL lsb_order got %h exp 01", l_data);
    end
    checks++;
    if (m_data !== 8'h80) begin
      errors++; $display("FAIL msb_order got %h exp 80", m_data);
    end
    tick();
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    send_frame(8'hA5);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_first got v=%b data=%h ovr=%b exp v=1 data=a5 ovr=0", m_valid, m_data, m_ovr);
    end
    send_frame(8'h3C);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_ovr !== 1'b1) begin
      errors++; $display("FAIL ovr_drop got v=%b data=%h ovr=%b exp v=1 data=a5 ovr=1", m_valid, m_data, m_ovr);
    end
    // Clear held across a whole frame whose completion is another overrun: the event wins.
    clr_flags = 1'b1;
    send_frame(8'h3C);
    checks++;
    if (m_ovr !== 1'b1 || m_data !== 8'hA5) begin
      errors++; $display("FAIL ovr_clr_race got ovr=%b data=%h exp ovr=1 data=a5", m_ovr, m_data);
    end
    tick();
    clr_flags = 1'b0;
    checks++;
    if (m_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_clear got %b exp 0", m_ovr);
    end
    word_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_drain got v=%b exp 0", m_valid);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] w;
    int         x0;
    w = 8'h81;
    word_ready = 1'b1;
    x0 = m_xfers;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    checks++;
    if (m_ferr !== 1'b0 || m_cnt !== 4'd5) begin
      errors++; $display("FAIL ferr_pre got ferr=%b cnt=%0d exp ferr=0 cnt=5", m_ferr, m_cnt);
    end
    send_bit(w[7], 1'b1);
    checks++;
    if (m_ferr !== 1'b1 || m_cnt !== 4'd1) begin
      errors++; $display("FAIL ferr_pulse got ferr=%b cnt=%0d exp ferr=1 cnt=1", m_ferr, m_cnt);
    end
    send_bit(w[6], 1'b0);
    checks++;
    if (m_ferr !== 1'b0) begin
      errors++; $display("FAIL ferr_one_cycle got %b exp 0", m_ferr);
    end
    for (int i = 5; i >= 0; i--) send_bit(w[i], 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h81) begin
      errors++; $display("FAIL ferr_word got v=%b data=%h exp v=1 data=81", m_valid, m_data);
    end
    tick();
    tick();
    checks++;
    if (m_xfers - x0 !== 1) begin
      errors++; $display("FAIL ferr_word_count got %0d exp 1", m_xfers - x0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'hFF;
    word_ready = 1'b0;
    send_frame(8'h00);
    for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h00) begin
      errors++; $display("FAIL b2b_hold got v=%b data=%h exp v=1 data=00", m_valid, m_data);
    end
    word_ready = 1'b1;
    send_bit(w[0], 1'b0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hFF || m_ovr !== 1'b0) begin
      errors++; $display("FAIL b2b_same_edge got v=%b data=%h ovr=%b exp v=1 data=ff ovr=0", m_valid, m_data, m_ovr);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got v=%b exp 0", m_valid);
    end
  endtask

  task automatic test_mid_frame_reset();
    word_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (m_cnt !== 4'd0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid got cnt=%0d v=%b exp cnt=0 v=0", m_cnt, m_valid);
    end
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    checks++;
    if (m_cnt !== 4'd0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ignore got cnt=%0d v=%b exp cnt=0 v=0", m_cnt, m_valid);
    end
    send_frame(8'h5A);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
      errors++; $display("FAIL rst_next_frame got v=%b data=%h exp v=1 data=5a", m_valid, m_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bit_order();
    test_overrun();
    test_frame_error();
    test_back_to_back();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
